dm_port_arbiter: RTL and testbench
==================================

Name: dm_port_arbiter

Overview:
- Two-requester controller for the single-port word data memory: requester 0 is the CPU load/store unit, requester 1 is the aux/debug loader.
- Round-robin arbitration; accepts one op per grant over a valid/ready handshake.
- Sequences the memory access and performs byte stores as explicit read-then-write (merge) cycles.
- Sits between the requesters and the data memory. The memory has a combinational read, a clocked write, and a word index of addr[11:2].

Parameters:
- ADDR_W, 32, byte address width passed through to memory
- DATA_W, 32, word width (fixed 32; SB merge logic assumes 4 byte lanes)

Ports:
- clk  in  1  system clock, all state on posedge
- Reset  in  1  synchronous, active-high reset
- reqN_valid  in  1  request N (N=0,1) present
- reqN_ready  out  1  request N accepted this cycle
- reqN_op  in  2  0=LW, 1=SW, 2=SB, 3=reserved
- reqN_addr  in  ADDR_W  byte address
- reqN_wdata  in  DATA_W  store data (SB uses [7:0])
- reqN_pc  in  32  PC of issuing instruction, for trace
- rspN_valid  out  1  one-cycle completion pulse for requester N
- rspN_rdata  out  DATA_W  LW result; 0 for SW/SB/reserved
- mem_addr  out  ADDR_W  word-aligned address {addr[31:2],2'b00}
- mem_we  out  1  write enable to memory
- mem_wdata  out  DATA_W  full word to write
- mem_rdata  in  DATA_W  combinational read data of mem_addr
- mem_pc  out  32  PC of op in flight

Behaviour:
- Reset (synchronous): state=IDLE, last_grant=1 (port 0 wins first), all outputs 0, latched op/addr/data/pc cleared.
- mem_we is gated by !Reset, so no write occurs in a reset cycle even if state is WRITE. An in-flight op is dropped with no response.
- IDLE:
  - reqN_ready is asserted combinationally only in IDLE, and only to the granted port.
  - Grant rule: if exactly one valid, grant it. If both are valid, grant the port != last_grant.
  - On handshake: latch op, addr, wdata, pc and port id; update last_grant; go to EXEC.
  - No grant when neither is valid.
- EXEC:
  - mem_addr is driven from the latched address.
  - LW: capture mem_rdata into rdata; go to IDLE.
  - SW: mem_we=1, mem_wdata=latched wdata; go to IDLE.
  - SB: capture mem_rdata into merge register; go to WRITE.
  - Reserved op: no access, rdata=0; go to IDLE.
- WRITE (SB only): mem_we=1. mem_wdata is the merge register with byte lane addr[1:0] replaced by wdata[7:0].
  - Lane 0 = bits [7:0], lane 3 = bits [31:24].
  - Go to IDLE.
- Response: rspN_valid is a registered pulse, asserted in the cycle after the final EXEC/WRITE cycle, for the latched port only.
  - rspN_rdata holds its value until the next response to that port.
- Latency (handshake in cycle T):
  - LW/SW/reserved: memory access in T+1, rsp in T+2.
  - SB: read in T+1, write in T+2, rsp in T+3.
- A new grant may occur in the same cycle as a response pulse (back-to-back), giving a peak throughput of one LW/SW per 2 cycles.
- Misaligned LW/SW: addr[1:0] ignored, word access.
- Request fields must stay stable while valid && !ready. A requester may drop valid without being granted.
- Both ports never receive ready in the same cycle.

Optional Feature:
- DM_ARB_TRACE_EN
- Defined: on every cycle with mem_we=1 (not in reset), $display("@%h: *%h <= %h", mem_pc, latched byte address, mem_wdata). For SB the printed data is the merged word.
- Undefined: no display statements compiled; all other behaviour identical.

Test Plan:
- Mem[0x10]=0x12345678; req0 LW addr 0x10 at T -> ready0=1 at T, mem_we=0 throughout, rsp0_valid at T+2 with rdata 0x12345678.
- Mem[0x10]=0x11223344; req1 SB addr 0x13, wdata 0xFFFFFFAB -> mem_we=1 only at T+2 with mem_wdata 0xAB223344, mem_addr 0x10; rsp1_valid at T+3, rdata 0.
- After reset, req0 and req1 both held valid with SW ops -> grants alternate 0,1,0,1 on every IDLE cycle; never both ready.
- req0 SB in progress; Reset=1 in its WRITE cycle -> mem_we=0 that cycle, next state IDLE, no rsp0_valid, last_grant=1.
- req0 op=3 addr 0x20 -> no mem_we, rsp0_valid at T+2 with rdata 0; req0 SW 0xDEADBEEF to 0x22 -> write 0xDEADBEEF at word 0x20.
- With DM_ARB_TRACE_EN, req0 SW pc 0x3000 addr 0x8 data 0x5 -> exactly one line "@00003000: *00000008 <= 00000005".

Source files
------------

// File: rtl/dm_port_arbiter.sv
// Round-robin arbiter in front of the single-port data memory; SB is done as read-merge-write.
// Define DM_ARB_TRACE_EN to print a line for every memory write.
module dm_port_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              Reset,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [1:0]        req0_op,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_wdata,
   input  logic [31:0]       req0_pc,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [1:0]        req1_op,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_wdata,
   input  logic [31:0]       req1_pc,
   output logic              rsp0_valid,
   output logic [DATA_W-1:0] rsp0_rdata,
   output logic              rsp1_valid,
   output logic [DATA_W-1:0] rsp1_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [31:0]       mem_pc
);

   typedef enum logic [1:0] {IDLE, EXEC, WRITE} state_t;

   localparam logic [1:0] OP_LW = 2'd0;
   localparam logic [1:0] OP_SW = 2'd1;
   localparam logic [1:0] OP_SB = 2'd2;

   state_t            state, state_next;
   logic              last_grant;
   logic              lat_port;
   logic [1:0]        lat_op;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata;
   logic [31:0]       lat_pc;
   logic [DATA_W-1:0] merge_word;
   logic [DATA_W-1:0] merged_word;
   logic              grant_valid;
   logic              grant_port;
   logic              handshake;
   logic              done;
   logic [DATA_W-1:0] done_rdata;

   // With both ports asking, the one that did not win last time gets the grant.
   always_comb begin
      grant_valid = req0_valid | req1_valid;
      grant_port  = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
   end

   always_comb begin
      merged_word = merge_word;
      case (lat_addr[1:0])
         2'd0:    merged_word[7:0]   = lat_wdata[7:0];
         2'd1:    merged_word[15:8]  = lat_wdata[7:0];
         2'd2:    merged_word[23:16] = lat_wdata[7:0];
         default: merged_word[31:24] = lat_wdata[7:0];
      endcase
   end

   always_comb begin
      state_next = state;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      mem_we     = 1'b0;
      mem_wdata  = '0;
      done       = 1'b0;
      done_rdata = '0;
      case (state)
         IDLE: begin
            if (grant_valid && !Reset) begin
               req0_ready = ~grant_port;
               req1_ready = grant_port;
               state_next = EXEC;
            end
         end
         EXEC: begin
            case (lat_op)
               OP_LW: begin
                  done       = 1'b1;
                  done_rdata = mem_rdata;
                  state_next = IDLE;
               end
               OP_SW: begin
                  mem_we     = ~Reset;
                  mem_wdata  = lat_wdata;
                  done       = 1'b1;
                  state_next = IDLE;
               end
               OP_SB: state_next = WRITE;
               default: begin
                  done       = 1'b1;
                  state_next = IDLE;
               end
            endcase
         end
         WRITE: begin
            mem_we     = ~Reset;
            mem_wdata  = merged_word;
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign handshake = req0_ready | req1_ready;
   assign mem_addr  = {lat_addr[ADDR_W-1:2], 2'b00};
   assign mem_pc    = lat_pc;

   always_ff @(posedge clk) begin
      if (Reset) state <= IDLE;
      else       state <= state_next;
   end

   // Latch the granted request, hold the SB read word, and register the completion pulse.
   always_ff @(posedge clk) begin
      if (Reset) begin
         last_grant <= 1'b1;
         lat_port   <= 1'b0;
         lat_op     <= '0;
         lat_addr   <= '0;
         lat_wdata  <= '0;
         lat_pc     <= '0;
         merge_word <= '0;
         rsp0_valid <= 1'b0;
         rsp1_valid <= 1'b0;
         rsp0_rdata <= '0;
         rsp1_rdata <= '0;
      end else begin
         rsp0_valid <= 1'b0;
         rsp1_valid <= 1'b0;
         if (handshake) begin
            last_grant <= grant_port;
            lat_port   <= grant_port;
            lat_op     <= grant_port ? req1_op    : req0_op;
            lat_addr   <= grant_port ? req1_addr  : req0_addr;
            lat_wdata  <= grant_port ? req1_wdata : req0_wdata;
            lat_pc     <= grant_port ? req1_pc    : req0_pc;
         end
         if (state == EXEC && lat_op == OP_SB) merge_word <= mem_rdata;
         if (done) begin
            if (lat_port) begin
               rsp1_valid <= 1'b1;
               rsp1_rdata <= done_rdata;
            end else begin
               rsp0_valid <= 1'b1;
               rsp0_rdata <= done_rdata;
            end
         end
      end
   end

`ifdef DM_ARB_TRACE_EN
   always @(posedge clk) begin
      if (mem_we) $display("@%h: *%h <= %h", mem_pc, lat_addr, mem_wdata);
   end
`endif

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Bench for dm_port_arbiter: directed scenarios then random traffic, checked against a
// transaction-level model that schedules grants, writes and responses by cycle number.
module tb_dm_port_arbiter;

   logic        clk = 1'b0;
   logic        Reset;
   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [1:0]  req0_op, req1_op;
   logic [31:0] req0_addr, req0_wdata, req0_pc, req1_addr, req1_wdata, req1_pc;
   logic        rsp0_valid, rsp1_valid;
   logic [31:0] rsp0_rdata, rsp1_rdata;
   logic [31:0] mem_addr, mem_wdata, mem_rdata, mem_pc;
   logic        mem_we;

   logic [31:0] mmem [0:1023];

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          idle_cyc = 0;
   int          we_cyc = -1;
   int          rsp_cyc = -1;
   logic [9:0]  we_idx;
   logic [31:0] we_addr_exp, we_data_exp, we_pc_exp, rsp_data;
   bit          rsp_port = 1'b0;
   bit          m_last = 1'b1;
   logic [31:0] m_rd0 = '0;
   logic [31:0] m_rd1 = '0;
   bit          gnt0 = 1'b0;
   bit          gnt1 = 1'b0;

   always #5 clk = ~clk;

   assign mem_rdata = mmem[mem_addr[11:2]];

   dm_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .Reset(Reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_pc(req0_pc),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_pc(req1_pc),
      .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
      .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_pc(mem_pc)
   );

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s cycle %0d got %h expected %h", tag, cyc, got, exp);
      end
   endtask

   task automatic setReq(input bit port, input logic [1:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] pc);
      if (port) begin
         req1_valid = 1'b1; req1_op = op; req1_addr = addr; req1_wdata = wdata; req1_pc = pc;
      end else begin
         req0_valid = 1'b1; req0_op = op; req0_addr = addr; req0_wdata = wdata; req0_pc = pc;
      end
   endtask

   function automatic logic [31:0] randomAddr();
      int idx;
      idx = $urandom_range(4, 7);
      return ($urandom() & 32'hFFFF_F000) | (32'(idx) << 2) | 32'($urandom_range(0, 3));
   endfunction

   // Move to the sampling point of the next cycle and retire requests accepted last cycle.
   task automatic nextCycle();
      @(negedge clk);
      if (gnt0) begin req0_valid = 1'b0; gnt0 = 1'b0; end
      if (gnt1) begin req1_valid = 1'b0; gnt1 = 1'b0; end
   endtask

   task automatic applyStimulus();
      if (req0_valid && ($urandom() % 10 == 0)) req0_valid = 1'b0;
      else if (!req0_valid && ($urandom() % 3 == 0))
         setReq(1'b0, 2'($urandom_range(0, 3)), randomAddr(), $urandom(), $urandom());
      if (req1_valid && ($urandom() % 10 == 0)) req1_valid = 1'b0;
      else if (!req1_valid && ($urandom() % 3 == 0))
         setReq(1'b1, 2'($urandom_range(0, 3)), randomAddr(), $urandom(), $urandom());
   endtask

   task automatic evalCycle(input bit rst);
      bit          e_r0, e_r1, e_we, gp;
      logic [1:0]  op;
      logic [31:0] a, w, p, old;
      logic [4:0]  sh;
      Reset = rst;
      #1;
      e_r0 = 1'b0; e_r1 = 1'b0; gp = 1'b0;
      if (!rst && cyc >= idle_cyc && (req0_valid || req1_valid)) begin
         gp   = (req0_valid && req1_valid) ? !m_last : req1_valid;
         e_r0 = !gp;
         e_r1 = gp;
      end
      checkOutput("ready0", 32'(req0_ready), 32'(e_r0));
      checkOutput("ready1", 32'(req1_ready), 32'(e_r1));
      checkOutput("both_ready", 32'(req0_ready & req1_ready), 32'd0);
      e_we = !rst && (cyc == we_cyc);
      checkOutput("mem_we", 32'(mem_we), 32'(e_we));
      if (e_we) begin
         checkOutput("mem_addr", mem_addr, we_addr_exp);
         checkOutput("mem_wdata", mem_wdata, we_data_exp);
         checkOutput("mem_pc", mem_pc, we_pc_exp);
      end
      if (cyc == rsp_cyc) begin
         if (rsp_port) m_rd1 = rsp_data;
         else          m_rd0 = rsp_data;
      end
      checkOutput("rsp0_valid", 32'(rsp0_valid), 32'(cyc == rsp_cyc && !rsp_port));
      checkOutput("rsp1_valid", 32'(rsp1_valid), 32'(cyc == rsp_cyc && rsp_port));
      checkOutput("rsp0_rdata", rsp0_rdata, m_rd0);
      checkOutput("rsp1_rdata", rsp1_rdata, m_rd1);

      if (rst) begin
         idle_cyc = cyc + 1;
         we_cyc   = -1;
         rsp_cyc  = -1;
         m_last   = 1'b1;
         m_rd0    = '0;
         m_rd1    = '0;
      end else begin
         if (e_we) mmem[we_idx] = we_data_exp;
         if (e_r0 || e_r1) begin
            op = gp ? req1_op    : req0_op;
            a  = gp ? req1_addr  : req0_addr;
            w  = gp ? req1_wdata : req0_wdata;
            p  = gp ? req1_pc    : req0_pc;
            m_last = gp;
            if (gp) gnt1 = 1'b1; else gnt0 = 1'b1;
            we_idx      = a[11:2];
            old         = mmem[a[11:2]];
            we_addr_exp = {a[31:2], 2'b00};
            we_pc_exp   = p;
            rsp_port    = gp;
            rsp_data    = '0;
            case (op)
               2'd0: begin
                  rsp_data = old;
                  rsp_cyc  = cyc + 2; idle_cyc = cyc + 2;
               end
               2'd1: begin
                  we_cyc = cyc + 1; we_data_exp = w;
                  rsp_cyc = cyc + 2; idle_cyc = cyc + 2;
               end
               2'd2: begin
                  sh = {a[1:0], 3'b000};
                  we_data_exp = (old & ~(32'hFF << sh)) | ({24'h0, w[7:0]} << sh);
                  we_cyc = cyc + 2;
                  rsp_cyc = cyc + 3; idle_cyc = cyc + 3;
               end
               default: begin
                  rsp_cyc = cyc + 2; idle_cyc = cyc + 2;
               end
            endcase
         end
      end
      cyc++;
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) begin
         nextCycle();
         evalCycle(1'b0);
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mmem[i] = $urandom();
      req0_valid = 1'b0; req0_op = '0; req0_addr = '0; req0_wdata = '0; req0_pc = '0;
      req1_valid = 1'b0; req1_op = '0; req1_addr = '0; req1_wdata = '0; req1_pc = '0;
      Reset = 1'b1;
      repeat (2) @(posedge clk);
      nextCycle();
      evalCycle(1'b1);

      // LW of a known word on port 0
      nextCycle();
      mmem[4] = 32'h1234_5678;
      setReq(1'b0, 2'd0, 32'h0000_0010, 32'h0, 32'h0000_0100);
      evalCycle(1'b0);
      idleCycles(3);

      // SB into lane 3 from port 1
      nextCycle();
      mmem[4] = 32'h1122_3344;
      setReq(1'b1, 2'd2, 32'h0000_0013, 32'hFFFF_FFAB, 32'h0000_0104);
      evalCycle(1'b0);
      idleCycles(4);

      // Fresh reset, then both ports streaming SW: grants must alternate starting with port 0
      nextCycle();
      evalCycle(1'b1);
      for (int i = 0; i < 12; i++) begin
         nextCycle();
         if (!req0_valid) setReq(1'b0, 2'd1, randomAddr(), $urandom(), $urandom());
         if (!req1_valid) setReq(1'b1, 2'd1, randomAddr(), $urandom(), $urandom());
         evalCycle(1'b0);
      end
      nextCycle();
      req0_valid = 1'b0; req1_valid = 1'b0;
      evalCycle(1'b0);
      idleCycles(3);

      // Reset lands on the WRITE cycle of an SB: no write, no response, port 0 wins next
      nextCycle();
      setReq(1'b0, 2'd2, 32'h0000_0015, 32'h0000_00CD, 32'h0000_0200);
      evalCycle(1'b0);
      nextCycle();
      evalCycle(1'b0);
      nextCycle();
      evalCycle(1'b1);
      nextCycle();
      setReq(1'b0, 2'd0, 32'h0000_0014, 32'h0, 32'h0000_0204);
      setReq(1'b1, 2'd0, 32'h0000_0018, 32'h0, 32'h0000_0208);
      evalCycle(1'b0);
      idleCycles(6);

      // Reserved op, then misaligned SW
      nextCycle();
      setReq(1'b0, 2'd3, 32'h0000_0020, 32'h5555_5555, 32'h0000_0300);
      evalCycle(1'b0);
      idleCycles(2);
      nextCycle();
      setReq(1'b0, 2'd1, 32'h0000_0022, 32'hDEAD_BEEF, 32'h0000_0304);
      evalCycle(1'b0);
      idleCycles(3);
      checkOutput("sw_word_0x20", mmem[8], 32'hDEAD_BEEF);

      // Random traffic from both ports
      for (int i = 0; i < 1500; i++) begin
         nextCycle();
         applyStimulus();
         evalCycle(1'b0);
      end
      nextCycle();
      req0_valid = 1'b0; req1_valid = 1'b0;
      evalCycle(1'b0);
      idleCycles(4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
